// File: rtl/uart_tx.sv
// rtl/uart_tx.sv - UART transmitter: one-entry holding register feeding an LSB-first shift engine
module uart_tx #(
  parameter int DATA_BITS   = 8,
  parameter int SB_TICKS    = 16,
  parameter int STOP_BITS   = 1,
  parameter int PARITY_MODE = 0
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 s_tick,
  input  logic                 tx_start,
  input  logic [DATA_BITS-1:0] din,
  output logic                 tx,
  output logic                 tx_ready,
  output logic                 tx_done_tick
);
  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] START  = 3'd1;
  localparam logic [2:0] DATA   = 3'd2;
  localparam logic [2:0] PARITY = 3'd3;
  localparam logic [2:0] STOP   = 3'd4;

  localparam int SW = (SB_TICKS > 1) ? $clog2(SB_TICKS) : 1;
  localparam int NW = $clog2(DATA_BITS);
  localparam logic [SW-1:0] S_LAST      = SW'(SB_TICKS - 1);
  localparam logic [NW-1:0] N_LAST_DATA = NW'(DATA_BITS - 1);
  localparam logic [NW-1:0] N_LAST_STOP = NW'(STOP_BITS - 1);

  logic [2:0]           state_q, state_n;
  logic [SW-1:0]        s_q, s_n;
  logic [NW-1:0]        n_q, n_n;
  logic [DATA_BITS-1:0] shift_q, shift_n;
  logic [DATA_BITS-1:0] hold_q, hold_n;
  logic [DATA_BITS-1:0] load_word;
  logic                 par_q, par_n;
  logic                 hold_full_q, hold_full_n;
  logic                 tx_q, tx_n;
  logic                 accept, bit_end, load;

  assign accept    = tx_start & ~hold_full_q;
  assign bit_end   = s_tick & (s_q == S_LAST);
  // A word accepted in the same cycle the last stop bit ends bypasses the holding register
  assign load_word = hold_full_q ? hold_q : din;

  always_comb begin
    state_n      = state_q;
    s_n          = s_q;
    n_n          = n_q;
    shift_n      = shift_q;
    par_n        = par_q;
    load         = 1'b0;
    tx_done_tick = 1'b0;
    case (state_q)
      IDLE: begin
        if (hold_full_q) begin
          load    = 1'b1;
          state_n = START;
          s_n     = '0;
        end
      end
      START: begin
        if (bit_end) begin
          s_n     = '0;
          n_n     = '0;
          state_n = DATA;
        end else if (s_tick) begin
          s_n = s_q + 1'b1;
        end
      end
      DATA: begin
        if (bit_end) begin
          s_n     = '0;
          shift_n = shift_q >> 1;
          if (n_q == N_LAST_DATA) begin
            n_n     = '0;
            state_n = (PARITY_MODE != 0) ? PARITY : STOP;
          end else begin
            n_n = n_q + 1'b1;
          end
        end else if (s_tick) begin
          s_n = s_q + 1'b1;
        end
      end
      PARITY: begin
        if (bit_end) begin
          s_n     = '0;
          n_n     = '0;
          state_n = STOP;
        end else if (s_tick) begin
          s_n = s_q + 1'b1;
        end
      end
      STOP: begin
        if (bit_end) begin
          s_n = '0;
          if (n_q != N_LAST_STOP) begin
            n_n = n_q + 1'b1;
          end else begin
            tx_done_tick = 1'b1;
            if (hold_full_q | accept) begin
              load    = 1'b1;
              state_n = START;
            end else begin
              state_n = IDLE;
            end
          end
        end else if (s_tick) begin
          s_n = s_q + 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase

    if (load) begin
      shift_n = load_word;
      par_n   = (PARITY_MODE == 2) ? ^load_word : ~^load_word;
    end

    hold_full_n = hold_full_q ? ~load : (accept & ~load);
    hold_n      = accept ? din : hold_q;

    // tx is registered from the next-state view so it changes on the same edge as the state
    case (state_n)
      START:   tx_n = 1'b0;
      DATA:    tx_n = shift_n[0];
      PARITY:  tx_n = par_n;
      default: tx_n = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      s_q         <= '0;
      n_q         <= '0;
      shift_q     <= '0;
      par_q       <= 1'b0;
      hold_q      <= '0;
      hold_full_q <= 1'b0;
      tx_q        <= 1'b1;
    end else begin
      state_q     <= state_n;
      s_q         <= s_n;
      n_q         <= n_n;
      shift_q     <= shift_n;
      par_q       <= par_n;
      hold_q      <= hold_n;
      hold_full_q <= hold_full_n;
      tx_q        <= tx_n;
    end
  end

  assign tx       = tx_q;
  assign tx_ready = ~hold_full_q;
endmodule

// File: tb/tb_uart_tx.sv
// tb/tb_uart_tx.sv - three uart_tx variants on shared stimulus, checked against a tick-level frame model
module tb_uart_tx;
  localparam int SB = 16;

  logic       clk = 1'b0;
  logic       reset;
  logic       s_tick;
  logic       tx_start;
  logic [7:0] din;
  logic [2:0] tx_w, rdy_w, done_w;

  uart_tx #(.DATA_BITS(8), .SB_TICKS(SB), .STOP_BITS(1), .PARITY_MODE(0)) u0 (
    .clk(clk), .reset(reset), .s_tick(s_tick), .tx_start(tx_start), .din(din),
    .tx(tx_w[0]), .tx_ready(rdy_w[0]), .tx_done_tick(done_w[0]));
  uart_tx #(.DATA_BITS(8), .SB_TICKS(SB), .STOP_BITS(1), .PARITY_MODE(2)) u1 (
    .clk(clk), .reset(reset), .s_tick(s_tick), .tx_start(tx_start), .din(din),
    .tx(tx_w[1]), .tx_ready(rdy_w[1]), .tx_done_tick(done_w[1]));
  uart_tx #(.DATA_BITS(8), .SB_TICKS(SB), .STOP_BITS(2), .PARITY_MODE(1)) u2 (
    .clk(clk), .reset(reset), .s_tick(s_tick), .tx_start(tx_start), .din(din),
    .tx(tx_w[2]), .tx_ready(rdy_w[2]), .tx_done_tick(done_w[2]));

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic int pm_of(input int i);
    return (i == 1) ? 2 : (i == 2) ? 1 : 0;
  endfunction

  function automatic int flen(input int i);
    return 1 + 8 + ((pm_of(i) != 0) ? 1 : 0) + ((i == 2) ? 2 : 1);
  endfunction

  // Whole frame as a bit vector: start, data LSB first, parity by ones count, then stop ones
  function automatic logic [15:0] mk_frame(input int i, input logic [7:0] d);
    logic [15:0] f;
    int ones;
    f    = '1;
    f[0] = 1'b0;
    for (int k = 0; k < 8; k++) f[1+k] = d[k];
    ones = $countones(d);
    if (pm_of(i) == 2) f[9] = (ones % 2 == 1);
    else if (pm_of(i) == 1) f[9] = (ones % 2 == 0);
    return f;
  endfunction

  bit          m_busy[3];
  int          m_ticks[3];
  bit          m_hfull[3];
  logic [7:0]  m_hold[3];
  logic [15:0] m_frame[3];

  always @(posedge clk or negedge reset) begin : mdl
    bit acc;
    int t;
    if (!reset) begin
      for (int i = 0; i < 3; i++) begin
        m_busy[i]  <= 1'b0;
        m_ticks[i] <= 0;
        m_hfull[i] <= 1'b0;
        m_hold[i]  <= 8'h00;
        m_frame[i] <= '1;
      end
    end else begin
      for (int i = 0; i < 3; i++) begin
        acc = tx_start && !m_hfull[i];
        t   = m_ticks[i] + (s_tick ? 1 : 0);
        if (m_busy[i]) begin
          if (t == flen(i) * SB) begin
            m_ticks[i] <= 0;
            if (m_hfull[i]) begin
              m_frame[i] <= mk_frame(i, m_hold[i]);
              m_hfull[i] <= 1'b0;
            end else if (acc) begin
              m_frame[i] <= mk_frame(i, din);
            end else begin
              m_busy[i] <= 1'b0;
            end
          end else begin
            m_ticks[i] <= t;
            if (acc) begin
              m_hfull[i] <= 1'b1;
              m_hold[i]  <= din;
            end
          end
        end else if (m_hfull[i]) begin
          m_busy[i]  <= 1'b1;
          m_ticks[i] <= 0;
          m_frame[i] <= mk_frame(i, m_hold[i]);
          m_hfull[i] <= 1'b0;
        end else if (acc) begin
          m_hfull[i] <= 1'b1;
          m_hold[i]  <= din;
        end
      end
    end
  end

  function automatic logic exp_tx(input int i);
    return m_busy[i] ? m_frame[i][m_ticks[i] / SB] : 1'b1;
  endfunction

  function automatic logic exp_done(input int i);
    return m_busy[i] && s_tick && (m_ticks[i] == flen(i) * SB - 1);
  endfunction

  bit chk_en = 1'b0;

  always @(negedge clk) begin
    if (chk_en && reset) begin
      for (int i = 0; i < 3; i++) begin
        check($sformatf("u%0d_tx", i), tx_w[i], exp_tx(i));
        check($sformatf("u%0d_ready", i), rdy_w[i], !m_hfull[i]);
        check($sformatf("u%0d_done", i), done_w[i], exp_done(i));
      end
    end
  end

  bit tick_en   = 1'b0;
  bit tick_rand = 1'b0;
  int tick_ph   = 0;

  initial begin
    s_tick = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (!tick_en) s_tick = 1'b0;
      else if (tick_rand) s_tick = ($urandom_range(0, 2) == 0);
      else begin
        s_tick  = (tick_ph == 3);
        tick_ph = (tick_ph + 1) % 4;
      end
    end
  end

  logic [11:0] smp[3];
  int          dn[3];
  int          extra;
  int          pause_changes;

  // Sends d, then samples every instance mid-bit and records the tick count of each done pulse
  task automatic frame(input logic [7:0] d, input int pause_at);
    int cnt;
    int cyc;
    logic held;
    @(posedge clk); #1 tx_start = 1'b1; din = d;
    @(posedge clk); #1 tx_start = 1'b0;
    @(negedge clk);
    check("ready_after_accept", rdy_w[0], 1'b0);
    @(negedge clk);
    check("ready_after_load", rdy_w[0], 1'b1);
    cnt = 0;
    extra = 0;
    pause_changes = 0;
    for (int i = 0; i < 3; i++) begin
      smp[i] = '1;
      dn[i]  = 0;
    end
    for (cyc = 0; cyc < 3000; cyc++) begin
      if (s_tick) begin
        cnt++;
        if (cnt % SB == SB / 2 && cnt / SB < 12)
          for (int i = 0; i < 3; i++) smp[i][cnt / SB] = tx_w[i];
      end
      for (int i = 0; i < 3; i++)
        if (done_w[i]) begin
          if (dn[i] == 0) dn[i] = cnt;
          else extra++;
        end
      if (dn[0] != 0 && dn[1] != 0 && dn[2] != 0) break;
      if (pause_at > 0 && s_tick && cnt == pause_at) begin
        tick_en = 1'b0;
        held = tx_w[0];
        repeat (100) begin
          @(negedge clk);
          if (tx_w[0] !== held) pause_changes++;
        end
        tick_en = 1'b1;
      end
      @(negedge clk);
    end
    check("frame_timeout", (dn[0] != 0 && dn[1] != 0 && dn[2] != 0), 1'b1);
  endtask

  task automatic wait_idle();
    int cyc;
    for (cyc = 0; cyc < 20000; cyc++) begin
      @(negedge clk);
      if (rdy_w == 3'b111 && !m_busy[0] && !m_busy[1] && !m_busy[2]) break;
    end
    check("idle_timeout", (cyc < 20000), 1'b1);
  endtask

  initial begin
    int cnt, cyc, phase, gap;
    logic [7:0] got;
    reset    = 1'b0;
    tx_start = 1'b0;
    din      = 8'h00;
    repeat (3) @(posedge clk);
    #2;
    check("rst_tx", tx_w, 3'b111);
    check("rst_ready", rdy_w, 3'b111);
    check("rst_done", done_w, 3'b000);
    @(posedge clk); #1 reset = 1'b1;
    chk_en  = 1'b1;
    tick_en = 1'b1;
    repeat (5) @(posedge clk);

    frame(8'hA5, 0);
    check("a5_bits", smp[0][9:0], 10'b1101001010);
    check("a5_done_tick", dn[0], 160);
    check("a5_par_even_done", dn[1], 176);
    check("a5_2stop_done", dn[2], 192);
    check("a5_single_done", extra, 0);
    wait_idle();

    frame(8'h07, 0);
    check("even_parity_07", smp[1][9], 1'b1);
    check("odd_parity_07", smp[2][9], 1'b0);
    check("even_stop", smp[1][10], 1'b1);
    check("two_stop_high", smp[2][11:10], 2'b11);
    check("two_stop_done", dn[2], 192);
    wait_idle();

    // back-to-back, with an ignored request while the holding register is full
    @(posedge clk); #1 tx_start = 1'b1; din = 8'h00;
    @(posedge clk); #1 tx_start = 1'b0;
    repeat (160) @(posedge clk);
    #1 tx_start = 1'b1; din = 8'hFF;
    @(posedge clk); #1 din = 8'h3C;
    @(negedge clk);
    check("ready_low_pending", rdy_w[0], 1'b0);
    repeat (3) @(posedge clk);
    #1 tx_start = 1'b0;
    @(negedge clk);
    check("ready_low_after_ignore", rdy_w[0], 1'b0);
    phase = 0; cnt = 0; gap = 0; got = 8'h00;
    for (cyc = 0; cyc < 3000; cyc++) begin
      @(negedge clk);
      if (phase == 1 && s_tick) begin
        cnt++;
        if (cnt % SB == SB / 2 && cnt / SB >= 1 && cnt / SB <= 8) got[cnt / SB - 1] = tx_w[0];
      end
      if (done_w[0]) begin
        if (phase == 0) begin phase = 1; cnt = 0; end
        else begin gap = cnt; break; end
      end
    end
    check("b2b_gap_ticks", gap, 160);
    check("b2b_second_data", got, 8'hFF);
    wait_idle();

    frame(8'h96, 40);
    check("stall_bits", smp[0][9:0], 10'b1100101100);
    check("stall_done_tick", dn[0], 160);
    check("stall_tx_hold", pause_changes, 0);
    wait_idle();

    // reset mid-DATA with a word pending
    @(posedge clk); #1 tx_start = 1'b1; din = 8'h81;
    @(posedge clk); #1 tx_start = 1'b0;
    repeat (100) @(posedge clk);
    #1 tx_start = 1'b1; din = 8'h42;
    @(posedge clk); #1 tx_start = 1'b0;
    repeat (20) @(posedge clk);
    #3 reset = 1'b0;
    #1;
    check("async_rst_tx", tx_w, 3'b111);
    check("async_rst_ready", rdy_w, 3'b111);
    check("async_rst_done", done_w, 3'b000);
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;
    repeat (20) @(negedge clk);
    check("post_rst_idle_tx", tx_w, 3'b111);
    frame(8'h55, 0);
    check("post_rst_bits", smp[0][9:0], 10'b1010101010);
    check("post_rst_done", dn[0], 160);
    wait_idle();

    tick_rand = 1'b1;
    for (int k = 0; k < 4000; k++) begin
      @(posedge clk);
      #1;
      tx_start = ($urandom_range(0, 3) == 0);
      din      = 8'($urandom);
    end
    #1 tx_start = 1'b0;
    wait_idle();

    chk_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
